particle_stream_router: RTL and testbench
=========================================

Name: particle_stream_router

Overview:
- Next-generation host/kernel stream steering block between the host AXIS link and NUM_CH particle caches.
- INIT mode: routes host-to-kernel beats to one cache per beat, selected by TDEST, with full valid/ready backpressure.
- DUMP mode: drains every cache in order 0..NUM_CH-1 back to the host. Beats whose null flag is set are discarded; output carries TDEST = source channel and a frame-final TLAST.

Parameters:
- AXIS_TDATA_WIDTH, 512, particle beat width.
- TDEST_WIDTH, 16, host TDEST width.
- NUM_CH, 4, number of particle caches (>=2, power of 2).
- NULL_BIT, 226, index of the null-particle flag inside a beat.
- CNT_WIDTH, 32, beat counter width.
- CH_W, $clog2(NUM_CH), derived channel index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- i_init_start  in  1  pulse: begin INIT
- i_dump_start  in  1  pulse: begin DUMP
- i_s_axis_h2k_tvalid/tready  in/out  1  host input handshake
- i_s_axis_h2k_tdata  in  AXIS_TDATA_WIDTH  host beat
- i_s_axis_h2k_tlast  in  1  end of init frame
- i_s_axis_h2k_tdest  in  TDEST_WIDTH  target channel
- o_m_axis_k2pc_tvalid  out  NUM_CH  per-cache valid
- o_m_axis_k2pc_tdata  out  NUM_CH*AXIS_TDATA_WIDTH  per-cache data
- i_m_axis_k2pc_tready  in  NUM_CH  per-cache ready
- i_s_axis_pc2k_tvalid  in  NUM_CH  per-cache dump valid
- i_s_axis_pc2k_tdata  in  NUM_CH*AXIS_TDATA_WIDTH  per-cache dump data
- i_s_axis_pc2k_tlast  in  NUM_CH  per-cache last dump beat
- o_s_axis_pc2k_tready  out  NUM_CH  per-cache dump ready
- o_m_axis_k2h_tvalid/tdata/tkeep/tlast/tdest  out  1/AXIS_TDATA_WIDTH/AXIS_TDATA_WIDTH/8/1/TDEST_WIDTH  host output
- i_m_axis_k2h_tready  in  1  host ready
- o_busy  out  1  state != IDLE
- o_init_done, o_dump_done  out  1  one-cycle completion pulses
- o_err_bad_dest  out  1  sticky error flag
- o_init_count, o_dump_count  out  CNT_WIDTH  beats delivered in the current or last operation

Behaviour:
- Reset (rst==0 at posedge) applies from any state, including mid-operation.
  - FSM goes to IDLE; all outputs go to 0; counters and error flag clear; all output slots empty.
  - In-flight beats are lost.
- FSM states: IDLE, INIT, DUMP, DONE.
- IDLE transitions:
  - i_init_start -> INIT; clears o_init_count and o_err_bad_dest.
  - i_dump_start -> DUMP with ch=0; clears o_dump_count.
  - Both asserted together: INIT wins and the dump start is dropped.
  - Start pulses outside IDLE are ignored.
- INIT:
  - dest = h2k_tdest. h2k_tready = (dest>=NUM_CH) || !slot_v[dest] || k2pc_tready[dest]. h2k_tready is 0 in every other state.
  - An accepted beat loads slot dest; o_m_axis_k2pc_tvalid[dest] rises the next cycle (latency 1) and o_init_count increments.
  - A slot holds valid and data stable until its own tready.
  - dest>=NUM_CH: beat consumed, dropped, o_err_bad_dest set.
  - An accepted beat with tlast -> DONE.
- DUMP:
  - Only o_s_axis_pc2k_tready[ch] may be high. It equals out_free = !k2h_tvalid || k2h_tready.
  - Accepted beat with data[NULL_BIT]==0: output register loads data, tkeep all-ones, tdest=ch; o_dump_count increments.
  - Accepted beat with data[NULL_BIT]==1: discarded, no output beat. Exception: if it is the final channel's tlast beat, emit a terminator beat (tdata 0, tkeep 0, tlast 1).
  - k2h_tlast = 1 only on the beat accepted with pc2k_tlast[NUM_CH-1].
  - pc2k_tlast[ch] accepted: ch increments. On the last channel -> DONE.
  - Output latency is 1 cycle; no beat is duplicated or dropped under k2h_tready toggling.
- DONE:
  - Waits until all k2pc slots (if from INIT) or the k2h register (if from DUMP) are empty.
  - Pulses o_init_done or o_dump_done for 1 cycle, then -> IDLE.
- Counters saturate at all-ones.

Decomposition:
- Shared package holds the state enum, NULL_BIT default, and the CH_W helper function.
- Sub-module: axis_reg_slice, a one-entry registered AXIS stage (valid/ready/data/keep/last/dest, ready = !valid || m_ready).
  - Instantiated NUM_CH times for the k2pc slots and once for k2h.

Test Plan:
- Init routing: start, send 8 beats with tdest 0,1,2,3,0,1,2,3 (last on beat 8), all readies high -> each cache gets 2 beats in order; o_init_count=8; o_init_done pulses once; FSM back to IDLE.
- Backpressure: k2pc_tready[2]=0 for 20 cycles while sending tdest=2 twice -> second beat stalls h2k_tready=0; other channels are unaffected; no loss.
- Bad dest: tdest=7 with NUM_CH=4 -> beat consumed, o_err_bad_dest=1 sticky, no k2pc valid.
- Dump with nulls: channels hold 3 beats each, middle beat null -> 8 host beats with tdest sequence 0,0,1,1,2,2,3,3; tlast only on the 8th; o_dump_count=8.
- Null final beat: channel 3's tlast beat has bit 226 set -> terminator beat tkeep=0, tlast=1 is emitted.
- Reset mid-DUMP with k2h_tready random -> all outputs 0 the next cycle; a fresh dump completes correctly. Simultaneous init/dump start -> INIT only.

Source files
------------

// File: rtl/particle_stream_router_pkg.sv
// Shared types and helpers for the particle stream router: FSM states,
// default null-flag position and the channel index width helper.
package particle_stream_router_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_INIT,
      S_DUMP,
      S_DONE
   } state_t;

   localparam int NULL_BIT_DEFAULT = 226;

   // Index width for n channels; never narrower than one bit.
   function automatic int ch_width(input int n);
      int w;
      w = 1;
      for (int i = 1; i < 32; i++) begin
         if ((1 << i) < n) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/particle_stream_router_axis_reg_slice.sv
// One-entry registered AXIS stage. Payload is an opaque bus so callers can
// pack whatever sideband (keep/last/dest) they need alongside the data.
module axis_reg_slice
   import particle_stream_router_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid_i,
   output logic              s_ready_o,
   input  logic [DATA_W-1:0] s_data_i,
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic [DATA_W-1:0] m_data_o
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;

   assign s_ready_o = !valid_q || m_ready_i;
   assign m_valid_o = valid_q;
   assign m_data_o  = data_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (s_valid_i && s_ready_o) begin
         valid_d = 1'b1;
         data_d  = s_data_i;
      end else if (m_ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/particle_stream_router.sv
// Host/kernel stream steering: INIT scatters host beats to per-cache slots by
// TDEST; DUMP gathers caches 0..NUM_CH-1 back to the host, dropping null beats.
module particle_stream_router
   import particle_stream_router_pkg::*;
#(
   parameter int AXIS_TDATA_WIDTH = 512,
   parameter int TDEST_WIDTH      = 16,
   parameter int NUM_CH           = 4,
   parameter int NULL_BIT         = NULL_BIT_DEFAULT,
   parameter int CNT_WIDTH        = 32
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               i_init_start,
   input  logic                               i_dump_start,
   input  logic                               i_s_axis_h2k_tvalid,
   output logic                               o_s_axis_h2k_tready,
   input  logic [AXIS_TDATA_WIDTH-1:0]        i_s_axis_h2k_tdata,
   input  logic                               i_s_axis_h2k_tlast,
   input  logic [TDEST_WIDTH-1:0]             i_s_axis_h2k_tdest,
   output logic [NUM_CH-1:0]                  o_m_axis_k2pc_tvalid,
   output logic [NUM_CH*AXIS_TDATA_WIDTH-1:0] o_m_axis_k2pc_tdata,
   input  logic [NUM_CH-1:0]                  i_m_axis_k2pc_tready,
   input  logic [NUM_CH-1:0]                  i_s_axis_pc2k_tvalid,
   input  logic [NUM_CH*AXIS_TDATA_WIDTH-1:0] i_s_axis_pc2k_tdata,
   input  logic [NUM_CH-1:0]                  i_s_axis_pc2k_tlast,
   output logic [NUM_CH-1:0]                  o_s_axis_pc2k_tready,
   output logic                               o_m_axis_k2h_tvalid,
   output logic [AXIS_TDATA_WIDTH-1:0]        o_m_axis_k2h_tdata,
   output logic [AXIS_TDATA_WIDTH/8-1:0]      o_m_axis_k2h_tkeep,
   output logic                               o_m_axis_k2h_tlast,
   output logic [TDEST_WIDTH-1:0]             o_m_axis_k2h_tdest,
   input  logic                               i_m_axis_k2h_tready,
   output logic                               o_busy,
   output logic                               o_init_done,
   output logic                               o_dump_done,
   output logic                               o_err_bad_dest,
   output logic [CNT_WIDTH-1:0]               o_init_count,
   output logic [CNT_WIDTH-1:0]               o_dump_count
);

   localparam int CH_W   = ch_width(NUM_CH);
   localparam int KEEP_W = AXIS_TDATA_WIDTH / 8;
   localparam int HPW    = TDEST_WIDTH + 1 + KEEP_W + AXIS_TDATA_WIDTH;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

   state_t                state_q, state_d;
   logic [CH_W-1:0]       ch_q, ch_d;
   logic                  from_dump_q, from_dump_d;
   logic                  err_q, err_d;
   logic [CNT_WIDTH-1:0]  init_cnt_q, init_cnt_d;
   logic [CNT_WIDTH-1:0]  dump_cnt_q, dump_cnt_d;

   logic                  in_init, in_dump;
   logic                  dest_ok, h2k_acc;
   logic [CH_W-1:0]       dest_idx;
   logic [NUM_CH-1:0]     slot_in_v, slot_in_rdy;

   logic [AXIS_TDATA_WIDTH-1:0] pc_data;
   logic                  pc_v, pc_last, pc_null, pc_rdy, pc_acc, last_ch, final_beat;
   logic                  k2h_in_v, k2h_in_rdy;
   logic [HPW-1:0]        k2h_in_pl, k2h_out_pl;

   assign in_init  = (state_q == S_INIT);
   assign in_dump  = (state_q == S_DUMP);

   assign dest_ok  = (i_s_axis_h2k_tdest < TDEST_WIDTH'(NUM_CH));
   assign dest_idx = i_s_axis_h2k_tdest[CH_W-1:0];
   // Out-of-range destinations are always accepted so a bad beat cannot wedge the host.
   assign o_s_axis_h2k_tready = in_init && (!dest_ok || slot_in_rdy[dest_idx]);
   assign h2k_acc  = i_s_axis_h2k_tvalid && o_s_axis_h2k_tready;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
      assign slot_in_v[i] = in_init && i_s_axis_h2k_tvalid && dest_ok && (dest_idx == CH_W'(i));
      axis_reg_slice #(.DATA_W(AXIS_TDATA_WIDTH)) u_slot (
         .clk       (clk),
         .rst       (rst),
         .s_valid_i (slot_in_v[i]),
         .s_ready_o (slot_in_rdy[i]),
         .s_data_i  (i_s_axis_h2k_tdata),
         .m_valid_o (o_m_axis_k2pc_tvalid[i]),
         .m_ready_i (i_m_axis_k2pc_tready[i]),
         .m_data_o  (o_m_axis_k2pc_tdata[i*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH])
      );
   end

   assign pc_data    = i_s_axis_pc2k_tdata[int'(ch_q)*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH];
   assign pc_v       = i_s_axis_pc2k_tvalid[ch_q];
   assign pc_last    = i_s_axis_pc2k_tlast[ch_q];
   assign pc_null    = pc_data[NULL_BIT];
   assign last_ch    = (ch_q == CH_W'(NUM_CH - 1));
   assign final_beat = last_ch && pc_last;
   assign pc_rdy     = in_dump && k2h_in_rdy;
   assign pc_acc     = pc_v && pc_rdy;
   assign o_s_axis_pc2k_tready = pc_rdy ? (NUM_CH'(1) << ch_q) : '0;

   // A null final beat still becomes an empty terminator so the host sees TLAST.
   assign k2h_in_v  = in_dump && pc_v && (!pc_null || final_beat);
   assign k2h_in_pl = {TDEST_WIDTH'(ch_q), final_beat,
                       pc_null ? {KEEP_W{1'b0}} : {KEEP_W{1'b1}},
                       pc_null ? {AXIS_TDATA_WIDTH{1'b0}} : pc_data};

   axis_reg_slice #(.DATA_W(HPW)) u_k2h (
      .clk       (clk),
      .rst       (rst),
      .s_valid_i (k2h_in_v),
      .s_ready_o (k2h_in_rdy),
      .s_data_i  (k2h_in_pl),
      .m_valid_o (o_m_axis_k2h_tvalid),
      .m_ready_i (i_m_axis_k2h_tready),
      .m_data_o  (k2h_out_pl)
   );

   assign {o_m_axis_k2h_tdest, o_m_axis_k2h_tlast, o_m_axis_k2h_tkeep, o_m_axis_k2h_tdata} = k2h_out_pl;

   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      from_dump_d = from_dump_q;
      err_d       = err_q;
      init_cnt_d  = init_cnt_q;
      dump_cnt_d  = dump_cnt_q;
      o_init_done = 1'b0;
      o_dump_done = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_init_start) begin
               state_d    = S_INIT;
               init_cnt_d = '0;
               err_d      = 1'b0;
            end else if (i_dump_start) begin
               state_d    = S_DUMP;
               ch_d       = '0;
               dump_cnt_d = '0;
            end
         end
         S_INIT: begin
            if (h2k_acc) begin
               if (!dest_ok) err_d = 1'b1;
               else          init_cnt_d = sat_inc(init_cnt_q);
               if (i_s_axis_h2k_tlast) begin
                  state_d     = S_DONE;
                  from_dump_d = 1'b0;
               end
            end
         end
         S_DUMP: begin
            if (pc_acc) begin
               if (!pc_null) dump_cnt_d = sat_inc(dump_cnt_q);
               if (pc_last) begin
                  if (last_ch) begin
                     state_d     = S_DONE;
                     from_dump_d = 1'b1;
                  end else begin
                     ch_d = ch_q + CH_W'(1);
                  end
               end
            end
         end
         S_DONE: begin
            if (from_dump_q ? !o_m_axis_k2h_tvalid : ~|o_m_axis_k2pc_tvalid) begin
               o_init_done = !from_dump_q;
               o_dump_done = from_dump_q;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         ch_q        <= '0;
         from_dump_q <= 1'b0;
         err_q       <= 1'b0;
         init_cnt_q  <= '0;
         dump_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         from_dump_q <= from_dump_d;
         err_q       <= err_d;
         init_cnt_q  <= init_cnt_d;
         dump_cnt_q  <= dump_cnt_d;
      end
   end

   assign o_busy         = (state_q != S_IDLE);
   assign o_err_bad_dest = err_q;
   assign o_init_count   = init_cnt_q;
   assign o_dump_count   = dump_cnt_q;

endmodule

// File: tb/tb_particle_stream_router.sv
// Bench for particle_stream_router: directed and randomized INIT/DUMP
// traffic checked against a queue-based model of the routing rules.
`timescale 1ns/1ps
module tb_particle_stream_router;
   localparam int W  = 512;
   localparam int TW = 16;
   localparam int NC = 4;
   localparam int NB = 226;
   localparam int CW = 32;
   localparam int KW = W / 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              i_init_start, i_dump_start;
   logic              i_s_axis_h2k_tvalid, o_s_axis_h2k_tready;
   logic [W-1:0]      i_s_axis_h2k_tdata;
   logic              i_s_axis_h2k_tlast;
   logic [TW-1:0]     i_s_axis_h2k_tdest;
   logic [NC-1:0]     o_m_axis_k2pc_tvalid;
   logic [NC*W-1:0]   o_m_axis_k2pc_tdata;
   logic [NC-1:0]     i_m_axis_k2pc_tready;
   logic [NC-1:0]     i_s_axis_pc2k_tvalid;
   logic [NC*W-1:0]   i_s_axis_pc2k_tdata;
   logic [NC-1:0]     i_s_axis_pc2k_tlast;
   logic [NC-1:0]     o_s_axis_pc2k_tready;
   logic              o_m_axis_k2h_tvalid;
   logic [W-1:0]      o_m_axis_k2h_tdata;
   logic [KW-1:0]     o_m_axis_k2h_tkeep;
   logic              o_m_axis_k2h_tlast;
   logic [TW-1:0]     o_m_axis_k2h_tdest;
   logic              i_m_axis_k2h_tready;
   logic              o_busy, o_init_done, o_dump_done, o_err_bad_dest;
   logic [CW-1:0]     o_init_count, o_dump_count;

   particle_stream_router dut (
      .clk(clk), .rst(rst),
      .i_init_start(i_init_start), .i_dump_start(i_dump_start),
      .i_s_axis_h2k_tvalid(i_s_axis_h2k_tvalid), .o_s_axis_h2k_tready(o_s_axis_h2k_tready),
      .i_s_axis_h2k_tdata(i_s_axis_h2k_tdata), .i_s_axis_h2k_tlast(i_s_axis_h2k_tlast),
      .i_s_axis_h2k_tdest(i_s_axis_h2k_tdest),
      .o_m_axis_k2pc_tvalid(o_m_axis_k2pc_tvalid), .o_m_axis_k2pc_tdata(o_m_axis_k2pc_tdata),
      .i_m_axis_k2pc_tready(i_m_axis_k2pc_tready),
      .i_s_axis_pc2k_tvalid(i_s_axis_pc2k_tvalid), .i_s_axis_pc2k_tdata(i_s_axis_pc2k_tdata),
      .i_s_axis_pc2k_tlast(i_s_axis_pc2k_tlast), .o_s_axis_pc2k_tready(o_s_axis_pc2k_tready),
      .o_m_axis_k2h_tvalid(o_m_axis_k2h_tvalid), .o_m_axis_k2h_tdata(o_m_axis_k2h_tdata),
      .o_m_axis_k2h_tkeep(o_m_axis_k2h_tkeep), .o_m_axis_k2h_tlast(o_m_axis_k2h_tlast),
      .o_m_axis_k2h_tdest(o_m_axis_k2h_tdest), .i_m_axis_k2h_tready(i_m_axis_k2h_tready),
      .o_busy(o_busy), .o_init_done(o_init_done), .o_dump_done(o_dump_done),
      .o_err_bad_dest(o_err_bad_dest), .o_init_count(o_init_count), .o_dump_count(o_dump_count)
   );

   typedef struct { int ch; logic [W-1:0] d; } pc_rec_t;
   typedef struct { logic [W-1:0] d; logic [TW-1:0] dest; logic last; } h2k_t;
   typedef struct { logic [W-1:0] d; logic [KW-1:0] keep; logic last; logic [TW-1:0] dest; } k2h_t;

   int total = 0;
   int bad = 0;
   h2k_t    h2k_q[$];
   pc_rec_t got_pc[$], exp_pc[$];
   k2h_t    got_h[$], exp_h[$];
   logic [W-1:0] pc_mem [NC][8];
   int      pc_len [NC];
   int      pc_idx [NC];
   bit      rand_gap, rand_rdy;
   bit      force_en [NC];
   bit      force_val [NC];
   int      init_pulses, dump_pulses, pc_fires;
   int      exp_dump_cnt;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd_data();
      logic [W-1:0] v;
      for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   // One clock: observe handshakes at the falling edge, then drive after the rising edge.
   task automatic step();
      logic          h_fire;
      logic [NC-1:0] p_fire;
      @(negedge clk);
      h_fire = i_s_axis_h2k_tvalid && o_s_axis_h2k_tready;
      for (int c = 0; c < NC; c++) begin
         if (o_m_axis_k2pc_tvalid[c] && i_m_axis_k2pc_tready[c])
            got_pc.push_back('{c, o_m_axis_k2pc_tdata[c*W +: W]});
         p_fire[c] = i_s_axis_pc2k_tvalid[c] && o_s_axis_pc2k_tready[c];
         if (p_fire[c]) pc_fires++;
      end
      if (o_m_axis_k2h_tvalid && i_m_axis_k2h_tready)
         got_h.push_back('{o_m_axis_k2h_tdata, o_m_axis_k2h_tkeep, o_m_axis_k2h_tlast, o_m_axis_k2h_tdest});
      if (o_init_done) init_pulses++;
      if (o_dump_done) dump_pulses++;
      @(posedge clk);
      #1;
      if (h_fire) void'(h2k_q.pop_front());
      if (!(i_s_axis_h2k_tvalid && !h_fire)) begin
         if (h2k_q.size() > 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
            i_s_axis_h2k_tvalid = 1'b1;
            i_s_axis_h2k_tdata  = h2k_q[0].d;
            i_s_axis_h2k_tdest  = h2k_q[0].dest;
            i_s_axis_h2k_tlast  = h2k_q[0].last;
         end else begin
            i_s_axis_h2k_tvalid = 1'b0;
         end
      end
      for (int c = 0; c < NC; c++) begin
         if (p_fire[c]) pc_idx[c]++;
         if (!(i_s_axis_pc2k_tvalid[c] && !p_fire[c])) begin
            if (pc_idx[c] < pc_len[c] && (!rand_gap || $urandom_range(0, 2) != 0)) begin
               i_s_axis_pc2k_tvalid[c]     = 1'b1;
               i_s_axis_pc2k_tdata[c*W +: W] = pc_mem[c][pc_idx[c]];
               i_s_axis_pc2k_tlast[c]      = (pc_idx[c] == pc_len[c] - 1);
            end else begin
               i_s_axis_pc2k_tvalid[c] = 1'b0;
            end
         end
         i_m_axis_k2pc_tready[c] = force_en[c] ? force_val[c]
                                 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      end
      i_m_axis_k2h_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic clear_op();
      got_pc.delete(); exp_pc.delete(); got_h.delete(); exp_h.delete();
      init_pulses = 0; dump_pulses = 0; pc_fires = 0;
   endtask

   task automatic add_h2k(input int dest, input bit last);
      logic [W-1:0] d;
      d = rnd_data();
      h2k_q.push_back('{d, TW'(dest), last});
      if (dest < NC) exp_pc.push_back('{dest, d});
   endtask

   task automatic load_pc(input int c, input int len, input logic [7:0] nmask);
      logic [W-1:0] d;
      for (int j = 0; j < len; j++) begin
         d = rnd_data();
         d[NB] = nmask[j];
         pc_mem[c][j] = d;
      end
      pc_len[c] = len;
      pc_idx[c] = 0;
   endtask

   // Expected host stream: channels in order, nulls dropped, final null becomes a terminator.
   task automatic build_dump_exp();
      bit last;
      exp_h.delete();
      exp_dump_cnt = 0;
      for (int c = 0; c < NC; c++) begin
         for (int j = 0; j < pc_len[c]; j++) begin
            last = (j == pc_len[c] - 1) && (c == NC - 1);
            if (!pc_mem[c][j][NB]) begin
               exp_h.push_back('{pc_mem[c][j], {KW{1'b1}}, last, TW'(c)});
               exp_dump_cnt++;
            end else if (last) begin
               exp_h.push_back('{{W{1'b0}}, {KW{1'b0}}, 1'b1, TW'(c)});
            end
         end
      end
   endtask

   task automatic start_op(input bit init, input bit dump);
      i_init_start = init;
      i_dump_start = dump;
      step();
      i_init_start = 1'b0;
      i_dump_start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while (o_busy && k < 3000) begin
         step();
         k++;
      end
      chk({tag, "_reach_idle"}, W'(o_busy), W'(0));
   endtask

   task automatic cmp_init(input string tag, input int cnt, input bit err);
      logic [W-1:0] ed[$], gd[$];
      for (int c = 0; c < NC; c++) begin
         ed.delete(); gd.delete();
         foreach (exp_pc[k]) if (exp_pc[k].ch == c) ed.push_back(exp_pc[k].d);
         foreach (got_pc[k]) if (got_pc[k].ch == c) gd.push_back(got_pc[k].d);
         chk($sformatf("%s_ch%0d_beats", tag, c), W'(gd.size()), W'(ed.size()));
         for (int k = 0; k < ed.size() && k < gd.size(); k++)
            chk($sformatf("%s_ch%0d_data%0d", tag, c, k), gd[k], ed[k]);
      end
      chk({tag, "_init_count"}, W'(o_init_count), W'(cnt));
      chk({tag, "_err"}, W'(o_err_bad_dest), W'(err));
      chk({tag, "_init_done_pulses"}, W'(init_pulses), W'(1));
   endtask

   task automatic cmp_dump(input string tag);
      chk({tag, "_host_beats"}, W'(got_h.size()), W'(exp_h.size()));
      for (int k = 0; k < exp_h.size() && k < got_h.size(); k++) begin
         chk($sformatf("%s_data%0d", tag, k), got_h[k].d, exp_h[k].d);
         chk($sformatf("%s_keep%0d", tag, k), W'(got_h[k].keep), W'(exp_h[k].keep));
         chk($sformatf("%s_last%0d", tag, k), W'(got_h[k].last), W'(exp_h[k].last));
         chk($sformatf("%s_dest%0d", tag, k), W'(got_h[k].dest), W'(exp_h[k].dest));
      end
      chk({tag, "_dump_count"}, W'(o_dump_count), W'(exp_dump_cnt));
      chk({tag, "_dump_done_pulses"}, W'(dump_pulses), W'(1));
   endtask

   task automatic clear_pc();
      for (int c = 0; c < NC; c++) begin
         pc_len[c] = 0;
         pc_idx[c] = 0;
      end
      i_s_axis_pc2k_tvalid = '0;
   endtask

   initial begin
      logic [W-1:0] first_bp;
      int nrand;
      rst = 1'b0;
      i_init_start = 1'b0; i_dump_start = 1'b0;
      i_s_axis_h2k_tvalid = 1'b0; i_s_axis_h2k_tdata = '0;
      i_s_axis_h2k_tlast = 1'b0; i_s_axis_h2k_tdest = '0;
      i_m_axis_k2pc_tready = '1; i_s_axis_pc2k_tvalid = '0;
      i_s_axis_pc2k_tdata = '0; i_s_axis_pc2k_tlast = '0;
      i_m_axis_k2h_tready = 1'b1;
      rand_gap = 1'b0; rand_rdy = 1'b0;
      for (int c = 0; c < NC; c++) begin force_en[c] = 1'b0; force_val[c] = 1'b1; end
      clear_pc();
      clear_op();

      // Reset state
      repeat (3) step();
      chk("rst_busy", W'(o_busy), W'(0));
      chk("rst_h2k_tready", W'(o_s_axis_h2k_tready), W'(0));
      chk("rst_k2pc_tvalid", W'(o_m_axis_k2pc_tvalid), W'(0));
      chk("rst_k2h_tvalid", W'(o_m_axis_k2h_tvalid), W'(0));
      chk("rst_counts", W'({o_init_count, o_dump_count}), W'(0));
      chk("rst_err", W'(o_err_bad_dest), W'(0));
      rst = 1'b1;
      step();

      // Init routing, all readies high
      clear_op();
      for (int k = 0; k < 8; k++) add_h2k(k % NC, k == 7);
      start_op(1'b1, 1'b0);
      wait_idle("route");
      cmp_init("route", 8, 1'b0);

      // Backpressure on channel 2
      clear_op();
      force_en[2] = 1'b1; force_val[2] = 1'b0;
      add_h2k(2, 0); add_h2k(0, 0); add_h2k(2, 0); add_h2k(1, 1);
      first_bp = exp_pc[0].d;
      start_op(1'b1, 1'b0);
      repeat (10) step();
      chk("bp_h2k_tready_stalled", W'(o_s_axis_h2k_tready), W'(0));
      chk("bp_slot2_valid", W'(o_m_axis_k2pc_tvalid[2]), W'(1));
      chk("bp_slot2_data", o_m_axis_k2pc_tdata[2*W +: W], first_bp);
      chk("bp_pending_beats", W'(h2k_q.size()), W'(2));
      chk("bp_ch0_delivered", W'(got_pc.size()), W'(1));
      repeat (10) step();
      force_en[2] = 1'b0;
      wait_idle("bp");
      cmp_init("bp", 4, 1'b0);

      // Bad destination
      clear_op();
      add_h2k(7, 0); add_h2k(1, 1);
      start_op(1'b1, 1'b0);
      wait_idle("baddest");
      cmp_init("baddest", 1, 1'b1);
      chk("baddest_total_k2pc", W'(got_pc.size()), W'(1));
      repeat (2) step();
      chk("baddest_sticky", W'(o_err_bad_dest), W'(1));

      // Randomized init with gaps, random readies and a few bad destinations
      clear_op();
      rand_gap = 1'b1; rand_rdy = 1'b1;
      nrand = 40;
      for (int k = 0; k < nrand; k++) add_h2k((k == 5) ? 9 : $urandom_range(0, 5), k == nrand - 1);
      start_op(1'b1, 1'b0);
      chk("rinit_err_cleared", W'(o_err_bad_dest), W'(0));
      wait_idle("rinit");
      cmp_init("rinit", exp_pc.size(), 1'b1);

      // Dump: 3 beats per channel, middle one null
      clear_op();
      for (int c = 0; c < NC; c++) load_pc(c, 3, 8'b010);
      build_dump_exp();
      start_op(1'b0, 1'b1);
      wait_idle("dnull");
      cmp_dump("dnull");

      // Dump whose final beat is null: expect an empty terminator
      clear_op();
      for (int c = 0; c < NC - 1; c++) load_pc(c, 2, 8'($urandom_range(0, 3)));
      load_pc(NC - 1, 3, 8'b100);
      build_dump_exp();
      start_op(1'b0, 1'b1);
      wait_idle("dterm");
      cmp_dump("dterm");

      // Random dump
      clear_op();
      for (int c = 0; c < NC; c++) load_pc(c, $urandom_range(1, 6), 8'($urandom_range(0, 255)));
      build_dump_exp();
      start_op(1'b0, 1'b1);
      wait_idle("drand");
      cmp_dump("drand");

      // Reset in the middle of a dump
      clear_op();
      for (int c = 0; c < NC; c++) load_pc(c, 6, 8'h00);
      start_op(1'b0, 1'b1);
      repeat (12) step();
      rst = 1'b0;
      step();
      chk("mrst_busy", W'(o_busy), W'(0));
      chk("mrst_k2h_tvalid", W'(o_m_axis_k2h_tvalid), W'(0));
      chk("mrst_k2h_tdata", o_m_axis_k2h_tdata, '0);
      chk("mrst_k2h_side", W'({o_m_axis_k2h_tkeep, o_m_axis_k2h_tlast, o_m_axis_k2h_tdest}), W'(0));
      chk("mrst_pc2k_tready", W'(o_s_axis_pc2k_tready), W'(0));
      chk("mrst_counts", W'({o_init_count, o_dump_count}), W'(0));
      chk("mrst_err", W'(o_err_bad_dest), W'(0));
      clear_pc();
      rst = 1'b1;
      step();

      // Fresh dump after reset
      clear_op();
      for (int c = 0; c < NC; c++) load_pc(c, $urandom_range(1, 5), 8'($urandom_range(0, 255)));
      build_dump_exp();
      start_op(1'b0, 1'b1);
      wait_idle("dfresh");
      cmp_dump("dfresh");

      // Simultaneous start: INIT wins, dump start dropped
      clear_op();
      rand_gap = 1'b0; rand_rdy = 1'b0;
      for (int c = 0; c < NC; c++) load_pc(c, 2, 8'h00);
      start_op(1'b1, 1'b1);
      chk("both_busy", W'(o_busy), W'(1));
      chk("both_in_init", W'(o_s_axis_h2k_tready), W'(1));
      add_h2k(3, 1);
      wait_idle("both");
      chk("both_init_pulses", W'(init_pulses), W'(1));
      chk("both_dump_pulses", W'(dump_pulses), W'(0));
      chk("both_no_pc2k", W'(pc_fires), W'(0));
      chk("both_dump_count_kept", W'(o_dump_count), W'(exp_dump_cnt));
      chk("both_init_count", W'(o_init_count), W'(1));
      clear_pc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
